iterative_divider: RTL
======================

Name: iterative_divider

Overview:
- Multi-cycle restoring divider for the MIPS DIV/DIVU path; replaces the single-cycle combinational array.
- Retires StepsPerCycle quotient bits per clock.
- Start/busy/done handshake lets the pipeline stall on HI/LO reads while the divide runs.
- Supports signed or unsigned operation, divide-by-zero flagging, and abort on pipeline flush.

Parameters:
- BitWidth, 32, operand/result width; must be ≥ 2.
- StepsPerCycle, 1, quotient bits resolved per cycle; must divide BitWidth (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- nReset  input  1  reset, asynchronous, active-low.
- start  input  1  launch request; sampled only when busy=0.
- abort  input  1  synchronous flush of an in-flight divide.
- isUnsigned  input  1  1 = DIVU, 0 = DIV (two's complement); captured with start.
- dividend  input  BitWidth  captured with start.
- divisor  input  BitWidth  captured with start.
- busy  output  1  divide in progress.
- done  output  1  one-cycle pulse; results valid and held from this cycle until the next accepted start.
- quotient  output  BitWidth  registered result.
- remainder  output  BitWidth  registered result.
- divByZero  output  1  registered; set with done when divisor was 0.

Behaviour:
- Reset values: busy=0, done=0, quotient=0, remainder=0, divByZero=0, state=IDLE, iteration counter=0.
- States:
  - IDLE (also the post-done state).
  - CALC: runs BitWidth/StepsPerCycle cycles.
  - FIXUP: applies signs and writes outputs.
- Accept: start=1 and busy=0 in cycle t.
  - Operands are captured, magnitudes formed (negate when signed and MSB=1), and the sign flags latched.
  - CALC begins in cycle t+1.
  - start while busy=1 is ignored.
  - start in the done cycle is accepted.
- CALC:
  - Each cycle applies StepsPerCycle restoring steps: shift the partial remainder (BitWidth+1 bits) left by one, subtract the divisor magnitude.
  - Result bit = NOT borrow; on borrow, restore.
  - The counter decrements each cycle; at 0 the state moves to FIXUP.
- FIXUP:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative (truncating division; the remainder takes the dividend's sign).
  - Outputs are registered, done is asserted in the next cycle, and the state returns to IDLE.
- Latency: start in cycle t → done in cycle t+BitWidth/StepsPerCycle+2. busy is high in cycles t+1 .. t+BitWidth/StepsPerCycle+1 and low in the done cycle.
- Divide by zero:
  - Skips CALC: start in t → FIXUP in t+1 → done in t+2.
  - quotient = all ones, remainder = original dividend (unsigned-form, no fixup), divByZero=1.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, divByZero=0.
- abort:
  - Highest priority, over start and over FIXUP completion.
  - Returns to IDLE next cycle with busy=0 and done=0.
  - quotient, remainder and divByZero keep their previous values.
- nReset asserted mid-operation: immediate return to reset values; no done is produced.

Optional Feature:
- Macro DIVIDER_EARLY_OUT_EN.
- Defined:
  - In the accept cycle, if |dividend| < |divisor| (magnitudes, divisor ≠ 0), go straight to FIXUP with quotient magnitude 0 and remainder magnitude |dividend|.
  - done in t+2, sign rules as normal.
- Undefined: every nonzero-divisor divide takes the full latency.

Decomposition:
- Package DividerPkg:
  - state enum (IDLE, CALC, FIXUP);
  - counter width constant $clog2(BitWidth/StepsPerCycle+1);
  - typedef for the partial-remainder width (BitWidth+1).
- Sub-module divider_step: a combinational single restoring step (inputs partial remainder, next dividend bit, divisor; outputs new remainder and quotient bit). It is chained StepsPerCycle times in a generate loop.

Test Plan:
- Unsigned 100 / 7, StepsPerCycle=1, start in cycle 0 → done in cycle 34, quotient=14, remainder=2, divByZero=0.
- Signed -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 5 / 0 → done in cycle 2, quotient=0xFFFFFFFF, remainder=5, divByZero=1.
- Handshake:
  - Divide 1000/10, then re-pulse start at cycle 10 with 9/3 → ignored; result 100/0 at cycle 34.
  - start in cycle 34 with 9/3 → quotient=3 at cycle 68.
  - abort at cycle 20 → busy=0 at cycle 21, no done, outputs unchanged.
- StepsPerCycle=4: unsigned 0xFFFFFFFF / 0x10 → done at cycle 10, quotient=0x0FFFFFFF, remainder=0xF.
- DIVIDER_EARLY_OUT_EN: unsigned 3 / 9 → done at cycle 2, quotient=0, remainder=3. Without the macro → done at cycle 34, same values.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// DividerPkg: shared FSM state type and sizing helpers for the iterative divider.
// Optional early-out path is enabled with DIVIDER_EARLY_OUT_EN (see iterative_divider).
package DividerPkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_e;

  localparam int DefWidth = 32;
  localparam int DefSteps = 1;

  function automatic int cnt_width(input int bw, input int spc);
    return $clog2(bw / spc + 1);
  endfunction

  localparam int CntWidth = cnt_width(DefWidth, DefSteps);

  typedef logic [DefWidth:0] prem_t;

endpackage

// File: rtl/iterative_divider_step.sv
// divider_step: one combinational restoring-division step.
// Shift in the next dividend bit, trial-subtract, keep or restore.
module divider_step #(
  parameter int BitWidth = 32
) (
  input  logic [BitWidth:0]   partial,
  input  logic                next_bit,
  input  logic [BitWidth-1:0] divisor,
  output logic [BitWidth:0]   result,
  output logic                q_bit
);

  logic [BitWidth+1:0] shifted;
  logic [BitWidth:0]   diff;
  logic                borrow;

  assign shifted = {partial, next_bit};
  assign borrow  = shifted < {2'b00, divisor};
  assign diff    = shifted[BitWidth:0] - {1'b0, divisor};
  assign result  = borrow ? shifted[BitWidth:0] : diff;
  assign q_bit   = ~borrow;

endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle signed/unsigned restoring divider.
// Define DIVIDER_EARLY_OUT_EN to skip CALC when |dividend| < |divisor|.
module iterative_divider
  import DividerPkg::*;
#(
  parameter int BitWidth      = 32,
  parameter int StepsPerCycle = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                start,
  input  logic                abort,
  input  logic                isUnsigned,
  input  logic [BitWidth-1:0] dividend,
  input  logic [BitWidth-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [BitWidth-1:0] quotient,
  output logic [BitWidth-1:0] remainder,
  output logic                divByZero
);

  localparam int Iters = BitWidth / StepsPerCycle;
  localparam int CntW  = cnt_width(BitWidth, StepsPerCycle);
  localparam logic [CntW-1:0] CntLoad = CntW'(Iters - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (BitWidth < 2 || (BitWidth % StepsPerCycle) != 0) begin : g_bad_cfg
    $error("iterative_divider: bad BitWidth/StepsPerCycle");
  end

  state_e state, state_n;

  logic [CntW-1:0]     cnt;
  logic [BitWidth-1:0] dmag;
  logic [BitWidth-1:0] qreg;
  logic [BitWidth:0]   prem;
  logic                neg_q;
  logic                neg_r;
  logic                dz;

  logic                neg_dd;
  logic                neg_dv;
  logic [BitWidth-1:0] mag_dd;
  logic [BitWidth-1:0] mag_dv;
  logic                zero_dv;
  logic                accept;
  logic                early;

  assign neg_dd  = ~isUnsigned & dividend[BitWidth-1];
  assign neg_dv  = ~isUnsigned & divisor[BitWidth-1];
  assign mag_dd  = neg_dd ? -dividend : dividend;
  assign mag_dv  = neg_dv ? -divisor : divisor;
  assign zero_dv = (divisor == '0);
  assign accept  = (state == IDLE) & start & ~abort;
  assign busy    = (state != IDLE);

`ifdef DIVIDER_EARLY_OUT_EN
  assign early = ~zero_dv & (mag_dd < mag_dv);
`else
  assign early = 1'b0;
`endif

  // qreg doubles as dividend shifter and quotient accumulator
  logic [BitWidth:0]        chain [StepsPerCycle+1];
  logic [StepsPerCycle-1:0] qbits;
  logic [BitWidth-1:0]      qnext;

  assign chain[0] = prem;

  for (genvar g = 0; g < StepsPerCycle; g++) begin : g_step
    divider_step #(
      .BitWidth (BitWidth)
    ) u_step (
      .partial  (chain[g]),
      .next_bit (qreg[BitWidth-1-g]),
      .divisor  (dmag),
      .result   (chain[g+1]),
      .q_bit    (qbits[StepsPerCycle-1-g])
    );
  end

  always_comb begin
    qnext = qreg << StepsPerCycle;
    qnext[StepsPerCycle-1:0] = qbits;
  end

  logic [BitWidth-1:0] q_fix;
  logic [BitWidth-1:0] r_fix;

  assign q_fix = neg_q ? -qreg : qreg;
  assign r_fix = neg_r ? -prem[BitWidth-1:0] : prem[BitWidth-1:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = (zero_dv | early) ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_n = FIXUP;
        end
      end
      FIXUP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt       <= '0;
      dmag      <= '0;
      qreg      <= '0;
      prem      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= CntLoad;
        dmag  <= mag_dv;
        neg_q <= neg_dd ^ neg_dv;
        neg_r <= neg_dd;
        dz    <= zero_dv;
        prem  <= '0;
        qreg  <= mag_dd;
        // divide-by-zero reports the raw dividend
        if (zero_dv) begin
          qreg <= dividend;
        end else if (early) begin
          qreg <= '0;
          prem <= {1'b0, mag_dd};
        end
      end else if (state == CALC) begin
        prem <= chain[StepsPerCycle];
        qreg <= qnext;
        cnt  <= cnt - CntOne;
      end else if (state == FIXUP) begin
        done      <= 1'b1;
        divByZero <= dz;
        quotient  <= dz ? '1 : q_fix;
        remainder <= dz ? qreg : r_fix;
      end
    end
  end

endmodule
